// File: rtl/simon_seq_engine_if.sv
// Simon engine front-end/LED bundle.
// master: switch side; slave: engine side.
interface simon_seq_engine_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] pattern;
  logic             enter;
  logic [WIDTH-1:0] pattern_leds;
  logic [2:0]       mode_leds;
  logic [AW:0]      level;

  modport master (
    output pattern,
    output enter,
    input  pattern_leds,
    input  mode_leds,
    input  level
  );

  modport slave (
    input  pattern,
    input  enter,
    output pattern_leds,
    output mode_leds,
    output level
  );
endinterface

// File: rtl/simon_seq_engine.sv
// Simon game engine: stores, plays back and checks patterns.
// Ports: clk, rst (sync high), bus (pattern/enter in, leds/level out).
module simon_seq_engine #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 8,
  parameter int PLAY_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  simon_seq_engine_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = (PLAY_TICKS > 1) ? $clog2(PLAY_TICKS) : 1;

  localparam logic [AW:0]   N_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   N_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] I_ONE  = AW'(1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(PLAY_TICKS - 1);

  typedef enum logic [2:0] {
    S_INPUT,
    S_PLAY,
    S_REP,
    S_DONE,
    S_WIN
  } state_e;

  state_e          state_q, state_d;
  logic [AW:0]     n_q, n_d;
  logic [AW-1:0]   i_q, i_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             mem_we;
  logic             submit;
  logic             last_step;
  logic             tick_end;
  logic [WIDTH-1:0] cur;

  assign submit    = bus.enter && $onehot(bus.pattern);
  assign last_step = ({1'b0, i_q} == (n_q - N_ONE));
  assign tick_end  = (tick_q == T_LAST);
  assign cur       = mem_q[i_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INPUT;
      n_q     <= '0;
      i_q     <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      tick_q  <= tick_d;
    end
  end

  // Sequence memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[n_q[AW-1:0]] <= bus.pattern;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    tick_d  = tick_q;
    mem_we  = 1'b0;
    unique case (state_q)
      S_INPUT: begin
        if (submit) begin
          mem_we  = !rst;
          n_d     = n_q + N_ONE;
          i_d     = '0;
          tick_d  = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        tick_d = tick_q + T_ONE;
        if (tick_end) begin
          tick_d = '0;
          if (last_step) begin
            i_d     = '0;
            state_d = S_REP;
          end else begin
            i_d = i_q + I_ONE;
          end
        end
      end
      S_REP: begin
        if (submit) begin
          if (bus.pattern != cur) begin
            i_d     = '0;
            tick_d  = '0;
            state_d = S_DONE;
          end else if (!last_step) begin
            i_d = i_q + I_ONE;
          end else begin
            i_d     = '0;
            state_d = (n_q == N_MAX) ? S_WIN : S_INPUT;
          end
        end
      end
      S_DONE: begin
        // Endless replay of the failed sequence.
        tick_d = tick_q + T_ONE;
        if (tick_end) begin
          tick_d = '0;
          i_d    = last_step ? '0 : i_q + I_ONE;
        end
      end
      S_WIN: begin
        state_d = S_WIN;
      end
      default: begin
        state_d = S_INPUT;
      end
    endcase
  end

  always_comb begin
    bus.pattern_leds = bus.pattern;
    bus.mode_leds    = 3'b001;
    unique case (state_q)
      S_INPUT: begin
        bus.pattern_leds = bus.pattern;
        bus.mode_leds    = 3'b001;
      end
      S_PLAY: begin
        bus.pattern_leds = cur;
        bus.mode_leds    = 3'b010;
      end
      S_REP: begin
        bus.pattern_leds = bus.pattern;
        bus.mode_leds    = 3'b100;
      end
      S_DONE: begin
        bus.pattern_leds = cur;
        bus.mode_leds    = 3'b111;
      end
      S_WIN: begin
        bus.pattern_leds = '1;
        bus.mode_leds    = 3'b101;
      end
      default: begin
        bus.pattern_leds = bus.pattern;
        bus.mode_leds    = 3'b001;
      end
    endcase
  end

  assign bus.level = n_q;

endmodule
